// File: rtl/vdf_square_sequencer.sv
// Job-side driver for the modular squaring unit: starts the squarer with x, counts
// t iteration pulses and returns y = x^(2^t) mod N on a ready/valid result port.
module vdf_square_sequencer #(
    parameter int MOD_LEN        = 1024,
    parameter int T_WIDTH        = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [MOD_LEN-1:0] job_x,
    input  logic [T_WIDTH-1:0] job_t,
    output logic               sq_start,
    output logic [MOD_LEN-1:0] sq_in,
    input  logic [MOD_LEN-1:0] sq_out,
    input  logic               sq_valid,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [MOD_LEN-1:0] res_y,
    output logic               res_err,
    input  logic               abort,
    output logic               busy,
    output logic [T_WIDTH-1:0] iter_count,
    output logic [1:0]         dbg_state
);

    // Handshakes: a job transfers on job_valid && job_ready, a result on res_valid && res_ready.
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic               job_ready_q;
    logic               sq_start_q;
    logic [MOD_LEN-1:0] sq_in_q;
    logic               res_valid_q;
    logic [MOD_LEN-1:0] res_y_q;
    logic               res_err_q;
    logic               busy_q;
    logic [T_WIDTH-1:0] iter_q;
    logic [T_WIDTH-1:0] t_q;
    logic [WD_W-1:0]    wd_q;

    logic [T_WIDTH-1:0] iter_d;
    logic [WD_W-1:0]    wd_d;

    assign iter_d = iter_q + T_WIDTH'(1);
    assign wd_d   = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            job_ready_q <= 1'b0;
            sq_start_q  <= 1'b0;
            sq_in_q     <= '0;
            res_valid_q <= 1'b0;
            res_y_q     <= '0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            iter_q      <= '0;
            t_q         <= '0;
            wd_q        <= '0;
        end else begin
            sq_start_q <= 1'b0;
            if (abort) begin
                state_q     <= S_IDLE;
                res_valid_q <= 1'b0;
                job_ready_q <= 1'b1;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (job_valid && job_ready_q) begin
                            sq_in_q     <= job_x;
                            t_q         <= job_t;
                            iter_q      <= '0;
                            wd_q        <= '0;
                            res_err_q   <= 1'b0;
                            job_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            // Zero iterations: the answer is x itself, the squarer is never started.
                            if (job_t == '0) begin
                                res_y_q     <= job_x;
                                res_valid_q <= 1'b1;
                                state_q     <= S_DONE;
                            end else begin
                                res_y_q    <= '0;
                                sq_start_q <= 1'b1;
                                state_q    <= S_START;
                            end
                        end else begin
                            job_ready_q <= 1'b1;
                        end
                    end
                    S_START: state_q <= S_RUN;
                    S_RUN: begin
                        if (sq_valid) begin
                            iter_q  <= iter_d;
                            wd_q    <= '0;
                            res_y_q <= sq_out;
                            if (iter_q == t_q - T_WIDTH'(1)) begin
                                res_valid_q <= 1'b1;
                                state_q     <= S_DONE;
                            end
                        end else if (wd_d == WD_MAX) begin
                            // Stalled squarer: report the last captured value with the error flag.
                            wd_q        <= wd_d;
                            res_err_q   <= 1'b1;
                            res_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            wd_q <= wd_d;
                        end
                    end
                    S_DONE: begin
                        if (res_ready) begin
                            res_valid_q <= 1'b0;
                            job_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign job_ready  = job_ready_q;
    assign sq_start   = sq_start_q;
    assign sq_in      = sq_in_q;
    assign res_valid  = res_valid_q;
    assign res_y      = res_y_q;
    assign res_err    = res_err_q;
    assign busy       = busy_q;
    assign iter_count = iter_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_vdf_square_sequencer.sv
// Directed bench for vdf_square_sequencer with a mod-23 squarer model of 3-cycle latency.
module tb_vdf_square_sequencer;

    localparam int MOD_LEN = 16;
    localparam int T_WIDTH = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               job_valid;
    logic               job_ready;
    logic [MOD_LEN-1:0] job_x;
    logic [T_WIDTH-1:0] job_t;
    logic               sq_start;
    logic [MOD_LEN-1:0] sq_in;
    logic [MOD_LEN-1:0] sq_out;
    logic               sq_valid;
    logic               res_valid;
    logic               res_ready;
    logic [MOD_LEN-1:0] res_y;
    logic               res_err;
    logic               abort;
    logic               busy;
    logic [T_WIDTH-1:0] iter_count;
    logic [1:0]         dbg_state;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    vdf_square_sequencer #(
        .MOD_LEN(MOD_LEN),
        .T_WIDTH(T_WIDTH),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_x(job_x), .job_t(job_t),
        .sq_start(sq_start), .sq_in(sq_in), .sq_out(sq_out), .sq_valid(sq_valid),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_err(res_err),
        .abort(abort), .busy(busy), .iter_count(iter_count), .dbg_state(dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Squarer model: free-running, one valid pulse every 3 cycles after a start
    logic [MOD_LEN-1:0] m_acc;
    int                 m_cnt;
    bit                 m_run;
    bit                 m_stall;
    bit                 m_stall_after_one = 1'b0;

    function automatic logic [MOD_LEN-1:0] sq23(input logic [MOD_LEN-1:0] a);
        logic [31:0] p;
        p = 32'(a) * 32'(a);
        return MOD_LEN'(p % 23);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_acc <= '0; m_cnt <= 0; m_run <= 1'b0; m_stall <= 1'b0;
            sq_valid <= 1'b0; sq_out <= '0;
        end else if (sq_start) begin
            m_acc <= sq_in; m_cnt <= 0; m_run <= 1'b1; m_stall <= 1'b0;
            sq_valid <= 1'b0;
        end else if (m_run && !m_stall) begin
            if (m_cnt == 2) begin
                m_cnt    <= 0;
                m_acc    <= sq23(m_acc);
                sq_out   <= sq23(m_acc);
                sq_valid <= 1'b1;
                if (m_stall_after_one) m_stall <= 1'b1;
            end else begin
                m_cnt    <= m_cnt + 1;
                sq_valid <= 1'b0;
            end
        end else begin
            sq_valid <= 1'b0;
        end
    end

    always @(posedge clk) if (sq_start === 1'b1) start_cnt <= start_cnt + 1;

    // Driver tasks and checking
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_job(input logic [MOD_LEN-1:0] x, input logic [T_WIDTH-1:0] t);
        job_valid = 1'b1; job_x = x; job_t = t;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_res(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        bit ok;
        int s0;
        int bad;
        int pulses;

        reset = 1'b0; job_valid = 1'b0; job_x = '0; job_t = '0;
        res_ready = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_job_ready", job_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_sq_start", sq_start, 0);
        check("rst_sq_in", sq_in, 0);
        check("rst_res_y", res_y, 0);
        check("rst_iter", iter_count, 0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_job_ready", job_ready, 1);

        // Basic run x=5 t=3 -> 2,4,16, then hold the result under backpressure
        s0 = start_cnt;
        send_job(16'd5, 8'd3);
        check("basic_sq_start", sq_start, 1);
        check("basic_sq_in", sq_in, 5);
        check("basic_busy", busy, 1);
        check("basic_job_ready", job_ready, 0);
        wait_res(100, ok);
        check("basic_res_timeout", ok, 1);
        check("basic_res_y", res_y, 16);
        check("basic_res_err", res_err, 0);
        check("basic_iter", iter_count, 3);
        check("basic_start_pulses", start_cnt - s0, 1);
        bad = 0; pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sq_valid === 1'b1) pulses++;
            if (res_y !== 16 || res_valid !== 1'b1 || job_ready !== 1'b0 || iter_count !== 3)
                bad++;
        end
        check("bp_hold_bad_cycles", bad, 0);
        check("bp_squarer_pulsing", pulses > 0, 1);
        take_result();
        check("bp_after_res_valid", res_valid, 0);
        check("bp_after_job_ready", job_ready, 1);
        check("bp_after_busy", busy, 0);

        // Second job x=3 t=1 -> 9
        send_job(16'd3, 8'd1);
        wait_res(100, ok);
        check("job2_res_timeout", ok, 1);
        check("job2_res_y", res_y, 9);
        check("job2_iter", iter_count, 1);
        take_result();

        // t=0 bypass: result one cycle after accept, squarer untouched
        s0 = start_cnt;
        send_job(16'd7, 8'd0);
        check("t0_res_valid", res_valid, 1);
        check("t0_res_y", res_y, 7);
        check("t0_res_err", res_err, 0);
        check("t0_sq_start", sq_start, 0);
        take_result();
        check("t0_no_start", start_cnt - s0, 0);
        check("t0_job_ready", job_ready, 1);

        // Abort after one of three iterations
        send_job(16'd5, 8'd3);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (iter_count === 1) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_reach_iter1", ok, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_job_ready", job_ready, 1);
        check("abort_res_valid", res_valid, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) bad++;
        end
        check("abort_no_result", bad, 0);

        // Watchdog: squarer stalls after its first iteration
        m_stall_after_one = 1'b1;
        send_job(16'd5, 8'd3);
        wait_res(200, ok);
        check("to_res_timeout", ok, 1);
        check("to_res_err", res_err, 1);
        check("to_res_y", res_y, 2);
        check("to_iter", iter_count, 1);
        take_result();
        m_stall_after_one = 1'b0;

        // Asynchronous reset in the middle of a run
        send_job(16'd5, 8'd3);
        repeat (4) @(negedge clk);
        check("mid_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sq_in", sq_in, 0);
        check("mid_rst_job_ready", job_ready, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_iter", iter_count, 0);
        check("mid_rst_sq_start", sq_start, 0);
        @(negedge clk);
        reset = 1'b1;
        s0 = start_cnt;
        @(negedge clk);
        check("mid_rel_job_ready", job_ready, 1);
        check("mid_rel_busy", busy, 0);
        repeat (10) @(negedge clk);
        check("mid_rel_no_start", start_cnt - s0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
